rr_arbiter_fsm_amisha: RTL

RR_ARBITER_FSM_AMISHA -- requirements
Module: rr_arbiter_fsm_amisha

---
 rtl/arb_pkg_amisha.sv | 16 +
 rtl/rr_pick_amisha.sv | 32 +++
 rtl/rr_arbiter_fsm_amisha.sv | 109 ++++++++++
 3 files changed

// File: rtl/arb_pkg_amisha.sv
// Shared definitions for the round-robin grant FSM: state encodings and default sizing.
package arb_pkg_amisha;

    localparam int NREQ_DEFAULT     = 4;
    localparam int HOLD_MAX_DEFAULT = 8;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_GRANT = 2'b01;
    localparam logic [1:0] ST_COOL  = 2'b10;

    // Width of an index into n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick_amisha.sv
// Rotating-priority search: first set request strictly after `last`, wrapping modulo NREQ.
module rr_pick_amisha
    import arb_pkg_amisha::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int IDW  = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] onehot,
    output logic [IDW-1:0]  index,
    output logic            valid
);

    always_comb begin
        int cand;
        onehot = '0;
        index  = '0;
        valid  = 1'b0;
        cand   = 0;
        // last itself is scanned last, so a lone requester can win back-to-back rounds.
        for (int i = 1; i <= NREQ; i++) begin
            cand = (int'(last) + i) % NREQ;
            if (!valid && req[cand]) begin
                valid        = 1'b1;
                onehot[cand] = 1'b1;
                index        = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_fsm_amisha.sv
// Round-robin arbiter with a bounded hold time: IDLE -> GRANT -> COOL -> IDLE.
// A grant ends on done, on the owner dropping its request, or on reaching HOLD_MAX cycles.
module rr_arbiter_fsm_amisha
    import arb_pkg_amisha::*;
#(
    parameter int NREQ     = NREQ_DEFAULT,
    parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
    input  logic                    clk_amisha,
    input  logic                    reset_n_amisha,
    input  logic [NREQ-1:0]         req_amisha,
    input  logic                    done_amisha,
    output logic [NREQ-1:0]         gnt_amisha,
    output logic [$clog2(NREQ)-1:0] gnt_id_amisha,
    output logic                    busy_amisha,
    output logic                    timeout_amisha
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(HOLD_MAX);
    localparam logic [CW-1:0]  CNT_LAST = CW'(HOLD_MAX - 1);
    localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IDW-1:0]  last_q, last_d;
    logic [NREQ-1:0] gnt_d;
    logic [IDW-1:0]  gnt_id_d;
    logic            timeout_d;

    logic [NREQ-1:0] pick_onehot;
    logic [IDW-1:0]  pick_index;
    logic            pick_valid;
    logic            release_now;

    rr_pick_amisha #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req    (req_amisha),
        .last   (last_q),
        .onehot (pick_onehot),
        .index  (pick_index),
        .valid  (pick_valid)
    );

    assign release_now = done_amisha || !req_amisha[gnt_id_amisha];
    assign busy_amisha = |gnt_amisha;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        gnt_d     = gnt_amisha;
        gnt_id_d  = gnt_id_amisha;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d  = ST_GRANT;
                    cnt_d    = '0;
                    gnt_d    = pick_onehot;
                    gnt_id_d = pick_index;
                end
            end
            ST_GRANT: begin
                // A release in the limit cycle takes precedence, so no timeout is flagged.
                if (release_now || cnt_q == CNT_LAST) begin
                    state_d   = ST_COOL;
                    cnt_d     = '0;
                    last_d    = gnt_id_amisha;
                    gnt_d     = '0;
                    gnt_id_d  = '0;
                    timeout_d = !release_now;
                end else begin
                    cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CW'(1);
                end
            end
            ST_COOL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                cnt_d    = '0;
                gnt_d    = '0;
                gnt_id_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
        if (!reset_n_amisha) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            last_q         <= LAST_RST;
            gnt_amisha     <= '0;
            gnt_id_amisha  <= '0;
            timeout_amisha <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            last_q         <= last_d;
            gnt_amisha     <= gnt_d;
            gnt_id_amisha  <= gnt_id_d;
            timeout_amisha <= timeout_d;
        end
    end

endmodule
